ahb_ram_slave: RTL and testbench

- AHB-Lite slave fronting the data RAM region (0xB000_0000). It sits directly downstream of the core's AHB master glue logic.
- Consumes htrans/haddr/hwrite/hsize/hwdata and returns hrdata/hreadyout/hresp.
- Supports a configurable number of wait states, byte/halfword/word writes, and two-cycle ERROR responses for illegal transfers.

---
 rtl/ahb_pkg.sv | 50 +++++
 rtl/ahb_ram_array.sv | 26 ++
 rtl/ahb_ram_slave.sv | 129 ++++++++++++
 tb/tb_ahb_ram_slave.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the data RAM slave.
// Transfer encodings, response codes and slave FSM states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

    function automatic logic [3:0] byte_strobe(
        input logic [2:0] size,
        input logic [1:0] lsb
    );
        logic [3:0] s;
        case (size)
            HSIZE_BYTE: s = 4'b0001 << lsb;
            HSIZE_HALF: s = 4'b0011 << {lsb[1], 1'b0};
            default:    s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic bad_align(
        input logic [2:0] size,
        input logic [1:0] lsb
    );
        return (size > HSIZE_WORD)
            || (size == HSIZE_HALF && lsb[0])
            || (size == HSIZE_WORD && lsb != 2'b00);
    endfunction

endpackage

// File: rtl/ahb_ram_array.sv
// Word-organised RAM with per-byte write enables.
// Writes land on the clock edge; reads are combinational.
module ahb_ram_array #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite slave for the data RAM window with optional wait states
// and two-cycle ERROR responses for illegal transfers.
module ahb_ram_slave
    import ahb_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'hB000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hreadyin,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int          ADDR_W = $clog2(DEPTH);
    localparam logic [31:0] SPAN   = 32'(DEPTH) << 2;
    localparam logic [3:0]  WS     = 4'(WAIT_STATES);

    slave_state_t      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [3:0]        strb_q, strb_d;

    htrans_t     tr;
    logic        tr_active;
    logic        accept;
    logic [31:0] offset;
    logic        illegal;
    logic        data_done;
    logic [3:0]  we;
    logic [31:0] ram_rdata;
    logic        unused_hprot;

    assign unused_hprot = ^hprot;

    assign tr        = htrans_t'(htrans);
    assign tr_active = (tr == HTRANS_NONSEQ) || (tr == HTRANS_SEQ);
    assign offset    = haddr - BASE_ADDR;
    assign illegal   = (offset >= SPAN) || bad_align(hsize, haddr[1:0]);

    // hreadyout gating keeps ERR1 and wait cycles deaf to the address bus
    assign accept = hsel && hreadyin && tr_active && hreadyout;

    assign data_done = (state_q == ST_DATA) && (cnt_q == 4'd0);

    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state_q)
            ST_DATA: hreadyout = (cnt_q == 4'd0);
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            ST_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        strb_d  = strb_q;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (state_q == ST_DATA && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else if (accept) begin
            addr_d  = offset[ADDR_W+1:2];
            write_d = hwrite;
            strb_d  = byte_strobe(hsize, haddr[1:0]);
            if (illegal) begin
                state_d = ST_ERR1;
                cnt_d   = 4'd0;
            end else begin
                state_d = ST_DATA;
                cnt_d   = WS;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            strb_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            strb_q  <= strb_d;
        end
    end

    // a write still pending when reset hits must not reach the array
    assign we = (data_done && write_q && hresetn) ? strb_q : 4'd0;

    assign hrdata = (data_done && !write_q) ? ram_rdata : 32'd0;

    ahb_ram_array #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (hclk),
        .we   (we),
        .addr (addr_q),
        .wdata(hwdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Scoreboard bench for ahb_ram_slave: two instances (0 and 3 wait
// states), a byte-level memory model, and a negedge response monitor.
module tb_ahb_ram_slave;
    import ahb_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'hB000_0000;
    localparam int          NI    = 2;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic        hresetn;
    logic        hsel      [NI];
    logic [31:0] haddr     [NI];
    logic [1:0]  htrans    [NI];
    logic        hwrite    [NI];
    logic [2:0]  hsize     [NI];
    logic [3:0]  hprot     [NI];
    logic [31:0] hwdata    [NI];
    logic [31:0] hrdata    [NI];
    logic        hreadyout [NI];
    logic        hresp     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ahb_ram_slave #(
            .DEPTH      (DEPTH),
            .BASE_ADDR  (BASE),
            .WAIT_STATES(g * 3)
        ) dut (
            .hclk     (hclk),
            .hresetn  (hresetn),
            .hsel     (hsel[g]),
            .haddr    (haddr[g]),
            .htrans   (htrans[g]),
            .hwrite   (hwrite[g]),
            .hsize    (hsize[g]),
            .hprot    (hprot[g]),
            .hwdata   (hwdata[g]),
            .hreadyin (hreadyout[g]),
            .hrdata   (hrdata[g]),
            .hreadyout(hreadyout[g]),
            .hresp    (hresp[g])
        );
    end

    typedef struct {
        int          k;
        logic        err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] mdl [NI][DEPTH];
    logic [31:0] pend_wd [NI];
    logic        dph [NI] = '{1'b0, 1'b0};
    int          wcnt = 0;
    logic [31:0] rs = 32'd0;

    // Reference: legality and byte merging straight from the AHB rules
    function automatic exp_t model(input int k, input logic w,
                                   input logic [31:0] a,
                                   input logic [2:0] sz,
                                   input logic [31:0] wd);
        exp_t        e;
        logic [31:0] off;
        int          n;
        int          idx;
        int          ln;
        off     = a - BASE;
        n       = (sz <= 3'd2) ? (1 << sz) : 1;
        e.k     = k;
        e.err   = (sz > 3'd2) || (off >= 32'(DEPTH * 4))
               || ((a % 32'(n)) != 0);
        e.waits = e.err ? 1 : k * 3;
        e.data  = 32'd0;
        if (!e.err) begin
            idx = int'(off / 4);
            if (w) begin
                for (int i = 0; i < n; i++) begin
                    ln = int'(a % 4) + i;
                    mdl[k][idx][ln*8 +: 8] = wd[ln*8 +: 8];
                end
            end else begin
                e.data = mdl[k][idx];
            end
        end
        return e;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, expv);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic issue(input int k, input logic sel,
                         input logic [1:0] tr, input logic w,
                         input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd);
        int b;
        hwdata[k] = pend_wd[k];
        hsel[k]   = sel;
        htrans[k] = tr;
        hwrite[k] = w;
        haddr[k]  = a;
        hsize[k]  = sz;
        hprot[k]  = 4'($urandom);
        b = 0;
        @(negedge hclk);
        while (!hreadyout[k] && b < 64) begin
            b++;
            @(negedge hclk);
        end
        if (b >= 64) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: inst %0d got stall, expected ready", k);
        end
        @(posedge hclk);
        if (sel && tr[1]) begin
            q.push_back(model(k, w, a, sz, wd));
            pend_wd[k] = wd;
        end
        #1;
    endtask

    always @(posedge hclk) begin
        for (int k = 0; k < NI; k++) begin
            if (!hresetn) dph[k] = 1'b0;
            else if (hreadyout[k]) dph[k] = hsel[k] && htrans[k][1];
        end
    end

    always @(negedge hclk) begin
        exp_t e;
        if (!hresetn) begin
            wcnt = 0;
            rs   = 32'd0;
            q.delete();
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (dph[k]) begin
                    rs = (rs << 1) | 32'(hresp[k]);
                    if (!hreadyout[k]) begin
                        wcnt++;
                    end else if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_resp: inst %0d got response, expected none", k);
                    end else begin
                        e = q.pop_front();
                        chk("resp_seq", rs, e.err ? 32'd3 : 32'd0);
                        chk("wait_cnt", 32'(wcnt), 32'(e.waits));
                        chk("rdata", hrdata[k], e.data);
                        wcnt = 0;
                        rs   = 32'd0;
                    end
                end
            end
        end
    end

    task automatic directed(input int k);
        issue(k, 1, 2'b10, 1, BASE + 32'h10, 3'd2, 32'hDEADBEEF);
        issue(k, 1, 2'b10, 0, BASE + 32'h10, 3'd2, 32'd0);
        issue(k, 1, 2'b10, 1, BASE + 32'h10, 3'd2, 32'h11223344);
        issue(k, 1, 2'b10, 1, BASE + 32'h11, 3'd0, 32'h0000AA00);
        issue(k, 1, 2'b10, 0, BASE + 32'h10, 3'd2, 32'd0);
        issue(k, 1, 2'b11, 1, BASE + 32'h12, 3'd1, 32'hBEEF0000);
        issue(k, 1, 2'b11, 0, BASE + 32'h10, 3'd2, 32'd0);
        issue(k, 1, 2'b10, 0, BASE + 32'h02, 3'd2, 32'd0);
        issue(k, 1, 2'b10, 1, BASE + 32'(DEPTH * 4), 3'd2, 32'h12345678);
        issue(k, 1, 2'b10, 1, BASE + 32'h10, 3'd3, 32'h12345678);
        issue(k, 1, 2'b10, 1, BASE - 32'd4, 3'd2, 32'h12345678);
        issue(k, 1, 2'b10, 1, BASE + 32'h13, 3'd1, 32'h12345678);
        issue(k, 1, 2'b10, 0, BASE + 32'h10, 3'd2, 32'd0);
        issue(k, 1, 2'b10, 1, BASE + 32'h20, 3'd2, 32'h00000055);
        issue(k, 1, 2'b10, 0, BASE + 32'h20, 3'd2, 32'd0);
        issue(k, 1, 2'b01, 0, BASE + 32'h20, 3'd2, 32'd0);
        issue(k, 0, 2'b00, 0, 32'd0, 3'd0, 32'd0);
    endtask

    task automatic random_run(input int k, input int n);
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  tr;
        int          r;
        for (int i = 0; i < n; i++) begin
            r  = int'($urandom_range(0, 15));
            tr = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 :
                 (r < 9) ? 2'b10 : 2'b11;
            sz = (r == 15) ? 3'(4 + $urandom_range(0, 3))
                           : 3'($urandom_range(0, 2));
            a  = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            if (r == 14) a = BASE + 32'(DEPTH * 4 + $urandom_range(0, 63));
            if (r == 13) a = BASE - 32'($urandom_range(1, 8));
            if (sz == 3'd1 && r > 4) a[0] = 1'b0;
            if (sz == 3'd2 && r > 4) a[1:0] = 2'b00;
            issue(k, (r != 12), tr, 1'($urandom), a, sz, $urandom);
        end
        issue(k, 0, 2'b00, 0, 32'd0, 3'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] save;
        int          b;
        hresetn = 1'b0;
        for (int k = 0; k < NI; k++) begin
            hsel[k]    = 1'b0;
            haddr[k]   = 32'd0;
            htrans[k]  = 2'b00;
            hwrite[k]  = 1'b0;
            hsize[k]   = 3'd0;
            hprot[k]   = 4'd0;
            hwdata[k]  = 32'd0;
            pend_wd[k] = 32'd0;
        end
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_ready", 32'(hreadyout[k]), 32'd1);
            chk("rst_resp", 32'(hresp[k]), 32'd0);
            chk("rst_rdata", hrdata[k], 32'd0);
        end
        @(posedge hclk);
        #1 hresetn = 1'b1;

        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                issue(k, 1, 2'b10, 1, BASE + 32'(i * 4), 3'd2, $urandom);
            end
            issue(k, 0, 2'b00, 0, 32'd0, 3'd0, 32'd0);
            directed(k);
            random_run(k, 200);
        end

        save = mdl[1][8];
        issue(1, 1, 2'b10, 1, BASE + 32'h20, 3'd2, 32'hCAFEF00D);
        hwdata[1] = pend_wd[1];
        hsel[1]   = 1'b0;
        htrans[1] = 2'b00;
        @(posedge hclk);
        #1 hresetn = 1'b0;
        @(posedge hclk);
        #1 hresetn = 1'b1;
        mdl[1][8] = save;
        @(negedge hclk);
        chk("post_rst_ready", 32'(hreadyout[1]), 32'd1);
        chk("post_rst_resp", 32'(hresp[1]), 32'd0);
        chk("post_rst_rdata", hrdata[1], 32'd0);
        @(posedge hclk);
        #1;
        issue(1, 1, 2'b10, 0, BASE + 32'h20, 3'd2, 32'd0);
        issue(1, 0, 2'b00, 0, 32'd0, 3'd0, 32'd0);

        b = 0;
        while (q.size() != 0 && b < 50) begin
            b++;
            @(negedge hclk);
        end
        chk("drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
